// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Multi-cycle load/store unit for the RV32I memory stage. It takes one
//   load or store per valid/ready handshake from execute, runs it on a data
//   bus that may insert wait states, and returns a one-cycle write-back
//   response. It generates byte enables and lane-replicated store data,
//   extracts and sign/zero extends load data, and rejects misaligned or
//   illegal-size requests without touching the bus.
//
// Parameters
//   DATA_W  : data bus width, 32 or 64
//   ADDR_W  : byte address width
//   TIMEOUT : BUS cycles without ack before an error response (1..255)
//
// Build option
//   LSU_TIMEOUT_EN : when defined, an 8-bit wait counter aborts a bus access
//                    after TIMEOUT cycles with rsp_err. When undefined, BUS
//                    waits for data_ack_i indefinitely.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   req_*               request from execute (valid/ready, we, size,
//                       unsigned, addr, wdata, rd)
//   rsp_*               one-cycle response (valid, we, rd, data, err)
//   stall_o             high whenever a request is in flight
//   data_ce_o/we_o/be_o/addr_o/data_o   bus request side
//   data_i, data_ack_i  bus completion side
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | req_ready high, waiting for a request
// BUS   | bus access in flight, outputs held until ack (or timeout)
// RESP  | one-cycle response pulse, then back to IDLE
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [4:0]          req_rd,
  output logic                rsp_valid,
  output logic                rsp_we,
  output logic [4:0]          rsp_rd,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                stall_o,
  output logic                data_ce_o,
  output logic                data_we_o,
  output logic [DATA_W/8-1:0] data_be_o,
  output logic [ADDR_W-1:0]   data_addr_o,
  output logic [DATA_W-1:0]   data_o,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                data_ack_i
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("load_store_unit: DATA_W must be 32 or 64");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("load_store_unit: TIMEOUT must be 1..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [4:0]        r_rd;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;

  logic              w_req_bad;
  logic              w_tmo_hit;
  logic [OFF_W-1:0]  w_off;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_st;
  logic [DATA_W-1:0] w_ld_sh;
  logic [DATA_W-1:0] w_keep;
  logic              w_fill;
  logic [DATA_W-1:0] w_ld_ext;

  // Misalignment and illegal size are decided from the live request so the
  // FSM can skip the bus entirely.
  function automatic logic f_bad(input logic [1:0] size, input logic [OFF_W-1:0] off);
    case (size)
      2'd0:    f_bad = 1'b0;
      2'd1:    f_bad = off[0];
      2'd2:    f_bad = (off[1:0] != 2'b00);
      default: f_bad = (DATA_W != 64) || (off != '0);
    endcase
  endfunction

  assign w_req_bad = f_bad(req_size, req_addr[OFF_W-1:0]);

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  logic [7:0] r_cnt;

  // Counter is held at zero outside BUS, so it is clear on every BUS entry.
  // The abort fires on the cycle whose increment would reach TIMEOUT, giving
  // exactly TIMEOUT cycles of data_ce_o.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= 8'd0;
    end else if (r_state != BUS) begin
      r_cnt <= 8'd0;
    end else if (!data_ack_i) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign w_tmo_hit = ((r_cnt + 8'd1) == TMO);
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Ack wins over timeout because it is tested first in both processes.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = w_req_bad ? RESP : BUS;
      BUS:     if (data_ack_i || w_tmo_hit) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we       <= 1'b0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= 5'd0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_rd       <= req_rd;
            r_err      <= w_req_bad;
            r_rdata    <= '0;
          end
        end
        BUS: begin
          if (data_ack_i) begin
            r_rdata <= r_we ? '0 : w_ld_ext;
          end else if (w_tmo_hit) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus-side datapath works only from captured fields, so every bus output
  // stays stable for the whole access regardless of what execute drives.
  assign w_off = r_addr[OFF_W-1:0];

  always_comb begin
    case (r_size)
      2'd0:    w_be = NB'(1) << w_off;
      2'd1:    w_be = NB'(3) << w_off;
      2'd2:    w_be = NB'(15) << w_off;
      default: w_be = '1;
    endcase
  end

  always_comb begin
    case (r_size)
      2'd0:    w_st = {NB{r_wdata[7:0]}};
      2'd1:    w_st = {(NB/2){r_wdata[15:0]}};
      2'd2:    w_st = {(NB/4){r_wdata[31:0]}};
      default: w_st = r_wdata;
    endcase
  end

  assign w_ld_sh = data_i >> {w_off, 3'b000};

  always_comb begin
    case (r_size)
      2'd0: begin
        w_keep = DATA_W'(8'hFF);
        w_fill = w_ld_sh[7];
      end
      2'd1: begin
        w_keep = DATA_W'(16'hFFFF);
        w_fill = w_ld_sh[15];
      end
      2'd2: begin
        w_keep = DATA_W'(32'hFFFF_FFFF);
        w_fill = w_ld_sh[31];
      end
      default: begin
        w_keep = '1;
        w_fill = w_ld_sh[DATA_W-1];
      end
    endcase
  end

  assign w_ld_ext = (w_ld_sh & w_keep) | ({DATA_W{w_fill & ~r_unsigned}} & ~w_keep);

  always_comb begin
    req_ready   = (r_state == IDLE);
    stall_o     = (r_state != IDLE);
    data_ce_o   = 1'b0;
    data_we_o   = 1'b0;
    data_be_o   = '0;
    data_addr_o = '0;
    data_o      = '0;
    rsp_valid   = 1'b0;
    rsp_we      = 1'b0;
    rsp_rd      = 5'd0;
    rsp_data    = '0;
    rsp_err     = 1'b0;
    if (r_state == BUS) begin
      data_ce_o   = 1'b1;
      data_we_o   = r_we;
      data_be_o   = w_be;
      data_addr_o = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      data_o      = r_we ? w_st : '0;
    end
    if (r_state == RESP) begin
      rsp_valid = 1'b1;
      rsp_we    = ~r_we & ~r_err;
      rsp_rd    = r_rd;
      rsp_data  = r_rdata;
      rsp_err   = r_err;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit instance, TIMEOUT=4
  logic        a_req_valid, a_req_ready, a_req_we, a_req_unsigned;
  logic [1:0]  a_req_size;
  logic [31:0] a_req_addr, a_req_wdata;
  logic [4:0]  a_req_rd, a_rsp_rd;
  logic        a_rsp_valid, a_rsp_we, a_rsp_err, a_stall, a_ce, a_we, a_ack;
  logic [31:0] a_rsp_data, a_addr_o, a_do, a_di;
  logic [3:0]  a_be;

  // 64-bit instance
  logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr;
  logic [63:0] b_req_wdata;
  logic [4:0]  b_req_rd, b_rsp_rd;
  logic        b_rsp_valid, b_rsp_we, b_rsp_err, b_stall, b_ce, b_we, b_ack;
  logic [63:0] b_rsp_data, b_do, b_di;
  logic [31:0] b_addr_o;
  logic [7:0]  b_be;

  load_store_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u32 (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_size(a_req_size), .req_unsigned(a_req_unsigned), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .req_rd(a_req_rd),
    .rsp_valid(a_rsp_valid), .rsp_we(a_rsp_we), .rsp_rd(a_rsp_rd),
    .rsp_data(a_rsp_data), .rsp_err(a_rsp_err), .stall_o(a_stall),
    .data_ce_o(a_ce), .data_we_o(a_we), .data_be_o(a_be), .data_addr_o(a_addr_o),
    .data_o(a_do), .data_i(a_di), .data_ack_i(a_ack)
  );

  load_store_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(16)) u64 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .req_rd(b_req_rd),
    .rsp_valid(b_rsp_valid), .rsp_we(b_rsp_we), .rsp_rd(b_rsp_rd),
    .rsp_data(b_rsp_data), .rsp_err(b_rsp_err), .stall_o(b_stall),
    .data_ce_o(b_ce), .data_we_o(b_we), .data_be_o(b_be), .data_addr_o(b_addr_o),
    .data_o(b_do), .data_i(b_di), .data_ack_i(b_ack)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        e_err;
    logic [3:0]  e_be;
    logic [31:0] e_do;
    logic [31:0] e_rsp;
  } vec_t;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        e_err;
    logic [7:0]  e_be;
    logic [31:0] e_addr;
    logic [63:0] e_do;
    logic [63:0] e_rsp;
  } vec64_t;

  vec_t   vt[13];
  vec64_t vb[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue32(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    a_req_valid = 1'b1; a_req_we = we; a_req_size = size; a_req_unsigned = uns;
    a_req_addr = addr; a_req_wdata = wdata; a_req_rd = rd;
    step();
    // scramble the request fields: the unit must work from what it captured
    a_req_valid = 1'b0; a_req_we = ~we; a_req_size = ~size; a_req_unsigned = ~uns;
    a_req_addr = 32'hFFFF_FFFF; a_req_wdata = 32'hFFFF_FFFF; a_req_rd = 5'd0;
  endtask

  task automatic run32(input vec_t v, input int idx);
    string t;
    logic [4:0] rd;
    t  = $sformatf("v%0d", idx);
    rd = 5'(idx + 1);
    chk({t, " ready"}, a_req_ready, 1);
    issue32(v.we, v.size, v.uns, v.addr, v.wdata, rd);
    if (v.e_err) begin
      chk({t, " ce"}, a_ce, 0);
      chk({t, " rsp_valid"}, a_rsp_valid, 1);
      chk({t, " rsp_err"}, a_rsp_err, 1);
      chk({t, " rsp_we"}, a_rsp_we, 0);
      chk({t, " rsp_data"}, a_rsp_data, 0);
    end else begin
      for (int w = 0; w <= v.waits; w++) begin
        chk($sformatf("%s ce c%0d", t, w + 1), a_ce, 1);
        chk($sformatf("%s be c%0d", t, w + 1), a_be, v.e_be);
        chk($sformatf("%s addr c%0d", t, w + 1), a_addr_o, v.addr & 32'hFFFF_FFFC);
        chk($sformatf("%s we c%0d", t, w + 1), a_we, v.we);
        if (v.we) chk($sformatf("%s data_o c%0d", t, w + 1), a_do, v.e_do);
        chk($sformatf("%s rsp_valid c%0d", t, w + 1), a_rsp_valid, 0);
        chk($sformatf("%s stall c%0d", t, w + 1), a_stall, 1);
        a_ack = (w == v.waits);
        a_di  = a_ack ? v.rdata : ~v.rdata;
        step();
      end
      a_ack = 1'b0; a_di = 32'h0;
      chk({t, " rsp_valid"}, a_rsp_valid, 1);
      chk({t, " rsp_err"}, a_rsp_err, 0);
      chk({t, " rsp_we"}, a_rsp_we, !v.we);
      chk({t, " rsp_data"}, a_rsp_data, v.e_rsp);
      chk({t, " rsp_rd"}, a_rsp_rd, rd);
      chk({t, " ce in resp"}, a_ce, 0);
    end
    step();
    chk({t, " pulse end"}, a_rsp_valid, 0);
    chk({t, " ready back"}, a_req_ready, 1);
  endtask

  task automatic run64(input vec64_t v, input int idx);
    string t;
    t = $sformatf("d%0d", idx);
    b_req_valid = 1'b1; b_req_we = v.we; b_req_size = v.size; b_req_unsigned = v.uns;
    b_req_addr = v.addr; b_req_wdata = v.wdata; b_req_rd = 5'd9;
    step();
    b_req_valid = 1'b0; b_req_addr = 32'hFFFF_FFFF; b_req_wdata = '1;
    if (!v.e_err) begin
      chk({t, " ce"}, b_ce, 1);
      chk({t, " be"}, b_be, v.e_be);
      chk({t, " addr"}, b_addr_o, v.e_addr);
      if (v.we) chk({t, " data_o"}, b_do, v.e_do);
      b_ack = 1'b1; b_di = v.rdata;
      step();
      b_ack = 1'b0; b_di = '0;
    end else begin
      chk({t, " ce"}, b_ce, 0);
    end
    chk({t, " rsp_valid"}, b_rsp_valid, 1);
    chk({t, " rsp_err"}, b_rsp_err, v.e_err);
    chk({t, " rsp_we"}, b_rsp_we, !v.we && !v.e_err);
    chk({t, " rsp_data"}, b_rsp_data, v.e_rsp);
    step();
    chk({t, " ready back"}, b_req_ready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;

    vt[0]  = '{1'b0, 2'd0, 1'b0, 32'h1003, 32'h0,         32'h80FF_FF00, 0, 1'b0, 4'b1000, 32'h0,         32'hFFFF_FF80};
    vt[1]  = '{1'b1, 2'd1, 1'b0, 32'h2002, 32'h1234,      32'h0,         3, 1'b0, 4'b1100, 32'h1234_1234, 32'h0};
    vt[2]  = '{1'b0, 2'd2, 1'b0, 32'h0001, 32'h0,         32'h0,         0, 1'b1, 4'b0000, 32'h0,         32'h0};
    vt[3]  = '{1'b0, 2'd3, 1'b0, 32'h0000, 32'h0,         32'h0,         0, 1'b1, 4'b0000, 32'h0,         32'h0};
    vt[4]  = '{1'b0, 2'd1, 1'b1, 32'h4002, 32'h0,         32'hBEEF_1234, 1, 1'b0, 4'b1100, 32'h0,         32'h0000_BEEF};
    vt[5]  = '{1'b0, 2'd1, 1'b0, 32'h4002, 32'h0,         32'hBEEF_1234, 0, 1'b0, 4'b1100, 32'h0,         32'hFFFF_BEEF};
    vt[6]  = '{1'b0, 2'd2, 1'b0, 32'h0010, 32'h0,         32'hDEAD_BEEF, 2, 1'b0, 4'b1111, 32'h0,         32'hDEAD_BEEF};
    vt[7]  = '{1'b1, 2'd0, 1'b0, 32'h0005, 32'hABCD_EFA5, 32'h0,         0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vt[8]  = '{1'b1, 2'd2, 1'b0, 32'h0008, 32'h0BAD_F00D, 32'h0,         1, 1'b0, 4'b1111, 32'h0BAD_F00D, 32'h0};
    vt[9]  = '{1'b1, 2'd1, 1'b0, 32'h0003, 32'h5555,      32'h0,         0, 1'b1, 4'b0000, 32'h0,         32'h0};
    vt[10] = '{1'b0, 2'd0, 1'b1, 32'h0002, 32'h0,         32'h00F2_3456, 0, 1'b0, 4'b0100, 32'h0,         32'h0000_00F2};
    vt[11] = '{1'b0, 2'd0, 1'b0, 32'h0001, 32'h0,         32'h0000_7F00, 0, 1'b0, 4'b0010, 32'h0,         32'h0000_007F};
    vt[12] = '{1'b1, 2'd2, 1'b0, 32'h0002, 32'h1,         32'h0,         0, 1'b1, 4'b0000, 32'h0,         32'h0};

    vb[0] = '{1'b0, 2'd3, 1'b0, 32'h8,  64'h0, 64'h8877_6655_4433_2211, 1'b0, 8'hFF, 32'h8,  64'h0, 64'h8877_6655_4433_2211};
    vb[1] = '{1'b0, 2'd0, 1'b0, 32'h5,  64'h0, 64'h0000_9A00_0000_0000, 1'b0, 8'h20, 32'h0,  64'h0, 64'hFFFF_FFFF_FFFF_FF9A};
    vb[2] = '{1'b0, 2'd2, 1'b1, 32'h4,  64'h0, 64'h8000_0001_DEAD_BEEF, 1'b0, 8'hF0, 32'h0,  64'h0, 64'h0000_0000_8000_0001};
    vb[3] = '{1'b0, 2'd2, 1'b0, 32'h4,  64'h0, 64'h8000_0001_DEAD_BEEF, 1'b0, 8'hF0, 32'h0,  64'h0, 64'hFFFF_FFFF_8000_0001};
    vb[4] = '{1'b1, 2'd2, 1'b0, 32'h4,  64'h1234_5678_CAFE_F00D, 64'h0, 1'b0, 8'hF0, 32'h0,  64'hCAFE_F00D_CAFE_F00D, 64'h0};
    vb[5] = '{1'b0, 2'd3, 1'b0, 32'hC,  64'h0, 64'h0, 1'b1, 8'h00, 32'h0,  64'h0, 64'h0};
    vb[6] = '{1'b1, 2'd1, 1'b0, 32'h6,  64'h0000_0000_0000_BEEF, 64'h0, 1'b0, 8'hC0, 32'h0,  64'hBEEF_BEEF_BEEF_BEEF, 64'h0};
    vb[7] = '{1'b1, 2'd3, 1'b0, 32'h10, 64'h0102_0304_0506_0708, 64'h0, 1'b0, 8'hFF, 32'h10, 64'h0102_0304_0506_0708, 64'h0};

    rst = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_size = 2'd0; a_req_unsigned = 1'b0;
    a_req_addr = 32'h0; a_req_wdata = 32'h0; a_req_rd = 5'd0; a_di = 32'h0; a_ack = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = 2'd0; b_req_unsigned = 1'b0;
    b_req_addr = 32'h0; b_req_wdata = 64'h0; b_req_rd = 5'd0; b_di = 64'h0; b_ack = 1'b0;
    step();
    step();
    chk("reset ready", a_req_ready, 1);
    chk("reset rsp_valid", a_rsp_valid, 0);
    chk("reset stall", a_stall, 0);
    chk("reset ce", a_ce, 0);
    chk("reset be", a_be, 0);
    chk("reset addr", a_addr_o, 0);
    chk("reset rsp_data", a_rsp_data, 0);
    chk("reset ready64", b_req_ready, 1);
    rst = 1'b1;
    step();

    for (int i = 0; i < 13; i++) run32(vt[i], i);
    for (int i = 0; i < 8; i++) run64(vb[i], i);

    // Ack while idle must be ignored
    a_ack = 1'b1; a_di = 32'h1234_5678;
    seen = 1'b0;
    repeat (3) begin
      step();
      seen = seen | a_rsp_valid | a_stall;
    end
    a_ack = 1'b0;
    chk("idle ack ignored", seen, 0);

`ifdef LSU_TIMEOUT_EN
    issue32(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 5'd7);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("tmo ce c%0d", c), a_ce, 1);
      step();
    end
    chk("tmo rsp_valid", a_rsp_valid, 1);
    chk("tmo rsp_err", a_rsp_err, 1);
    chk("tmo rsp_we", a_rsp_we, 0);
    chk("tmo rsp_data", a_rsp_data, 0);
    chk("tmo ce dropped", a_ce, 0);
    step();
    chk("tmo ready back", a_req_ready, 1);

    // Ack on the timeout cycle wins
    issue32(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 5'd8);
    repeat (3) step();
    chk("tie ce c4", a_ce, 1);
    a_ack = 1'b1; a_di = 32'h1122_3344;
    step();
    a_ack = 1'b0;
    chk("tie rsp_valid", a_rsp_valid, 1);
    chk("tie rsp_err", a_rsp_err, 0);
    chk("tie rsp_data", a_rsp_data, 32'h1122_3344);
    chk("tie rsp_we", a_rsp_we, 1);
    step();
`else
    issue32(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 5'd7);
    seen = 1'b0;
    repeat (100) begin
      seen = seen | a_rsp_valid;
      step();
    end
    chk("no tmo rsp", seen, 0);
    chk("no tmo stall", a_stall, 1);
    chk("no tmo ce", a_ce, 1);
    a_ack = 1'b1; a_di = 32'h1122_3344;
    step();
    a_ack = 1'b0;
    chk("late ack rsp_valid", a_rsp_valid, 1);
    chk("late ack rsp_err", a_rsp_err, 0);
    chk("late ack rsp_data", a_rsp_data, 32'h1122_3344);
    step();
`endif

    // Reset during the second wait state, then a late ack
    issue32(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 5'd3);
    chk("rstbus ce c1", a_ce, 1);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rstbus ready", a_req_ready, 1);
    chk("rstbus ce", a_ce, 0);
    chk("rstbus stall", a_stall, 0);
    a_ack = 1'b1; a_di = 32'hCAFE_BABE;
    seen = 1'b0;
    repeat (3) begin
      seen = seen | a_rsp_valid;
      step();
    end
    a_ack = 1'b0;
    chk("rstbus no rsp", seen | a_rsp_valid, 0);

    // Unit still works after the abort
    run32(vt[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Parametrised, multi-cycle load/store unit replacing the purely combinational memory-stage path of the RV32I core. Accepts one load or store per request from the execute stage over a valid/ready handshake, drives a data-memory bus that may insert wait states, and returns a write-back response. The bus side adds byte enables, sign/zero extension, misalignment detection and an optional bus timeout.

## Interface
Parameters:
- DATA_W, 32: data bus width, 32 or 64.
- ADDR_W, 32: address width.
- TIMEOUT, 16: bus wait cycles before an error response (1..255).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low; sampled on rising edge of clk.
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 doubleword (legal only when DATA_W=64).
- req_unsigned  in  1  load zero-extends when 1.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- req_rd  in  5  destination register of a load.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_we  out  1  register write enable (load without error).
- rsp_rd  out  5  destination register.
- rsp_data  out  DATA_W  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal size or timeout.
- stall_o  out  1  high whenever state is not IDLE.
- data_ce_o  out  1  bus request.
- data_we_o  out  1  bus write.
- data_be_o  out  DATA_W/8  byte-lane enables.
- data_addr_o  out  ADDR_W  lane-aligned address (low log2(DATA_W/8) bits 0).
- data_o  out  DATA_W  lane-replicated store data.
- data_i  in  DATA_W  load data, valid with data_ack_i.
- data_ack_i  in  1  bus completes the access this cycle.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: req_ready=1. On req_valid, capture all request fields. If aligned and size legal, go to BUS. Otherwise go to RESP with err=1 and make no bus access.
- Offset off = addr[log2(DATA_W/8)-1:0]. Misaligned when: half with off[0]≠0; word with off[1:0]≠0; doubleword with off≠0.
- BUS: hold data_ce_o=1 and keep every bus output stable until data_ack_i. On ack, capture data_i and go to RESP.
- Byte enables: byte = 1<<off; half = 2'b11<<off; word = 4'hF<<off; doubleword = all ones.
- Store data: the sized field of req_wdata is replicated across all lanes.
- Load data: data_i >> (8·off), truncated to size, then sign-extended (req_unsigned=0) or zero-extended to DATA_W.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_we = load & !err.
- A data_ack_i outside BUS is ignored.

## Timing
- Reset: on rst=0 at an edge, state becomes IDLE. All outputs are 0 except req_ready=1. Any in-flight transaction is dropped with no response, including one in BUS or RESP.
- Request accepted at edge 0. data_ce_o is high from cycle 1.
- If ack arrives in cycle k (k≥1), rsp_valid is high in cycle k+1. With zero wait states the latency is 2 cycles. req_ready returns in cycle k+2.
- Error without bus access: rsp_valid in cycle 1.
- Back-to-back throughput: one access per 3 cycles minimum.
- Timeout counter is 8 bits. It clears on entry to BUS and increments each BUS cycle without ack. When it reaches TIMEOUT, the unit goes to RESP with err=1 and drops data_ce_o.
- Ack and timeout in the same cycle: ack wins, no error.

## Configuration
- LSU_TIMEOUT_EN defined: timeout counter and timeout error are present as described.
- LSU_TIMEOUT_EN undefined: no counter; BUS waits indefinitely for data_ack_i; rsp_err reports only misalignment and illegal size.

## Test plan
- Byte load, zero-wait bus: DATA_W=32, addr 0x1003, signed, data_i=0x80FF_FF00 with immediate ack → data_be_o=4'b1000, rsp_data=0xFFFF_FF80, rsp_valid 2 cycles after acceptance.
- Half store with 3 wait states: addr 0x2002, wdata 0x1234 → data_be_o=4'b1100, data_o=0x1234_1234, bus outputs stable 4 cycles, rsp_valid the cycle after ack, rsp_we=0.
- Misaligned word load at 0x0001 → no data_ce_o, rsp_valid cycle 1 with rsp_err=1, rsp_we=0, rsp_data=0.
- Timeout with TIMEOUT=4, LSU_TIMEOUT_EN defined, no ack → data_ce_o high 4 cycles, then rsp_err=1. Without the macro, the unit is still stalled after 100 cycles.
- Reset mid-BUS: drive rst=0 during wait state 2, then a late ack → no rsp_valid; req_ready=1 after the reset edge.
- DATA_W=64 doubleword load at 0x8 → data_be_o=8'hFF, rsp_data=data_i. Size 3 with DATA_W=32 → rsp_err=1.
